// File: rtl/decode_stage_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, immediate types,
// FSM states and the default datapath width.
package decode_stage_pkg;

   localparam int WIDTH_DATA_DEFAULT = 32;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } imm_type_e;

   typedef enum logic {
      RUN,
      STALL
   } state_e;

   function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
      case (opcode)
         OP_IMM, OP_LOAD, OP_JALR: return IMM_I;
         OP_STORE:                 return IMM_S;
         OP_BRANCH:                return IMM_B;
         OP_LUI, OP_AUIPC:         return IMM_U;
         OP_JAL:                   return IMM_J;
         default:                  return IMM_NONE;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate extraction, sign-extended to WIDTH_DATA.
module imm_gen
   import decode_stage_pkg::*;
#(
   parameter int WIDTH_DATA = WIDTH_DATA_DEFAULT
) (
   input  logic [31:0]           instr,
   output logic [WIDTH_DATA-1:0] imm
);

   logic signed [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (imm_type_of(instr[6:0]))
         IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U: imm32 = {instr[31:12], 12'b0};
         IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm = WIDTH_DATA'(imm32);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with ID/EX output register and load-use stall FSM.
// Optional writeback-to-operand bypass enabled by defining DECODE_WB_BYPASS_EN.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int WIDTH_DATA = WIDTH_DATA_DEFAULT
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [31:0]           instr_i,
   input  logic [31:0]           pc_i,
   input  logic                  flush_i,
   output logic [4:0]            rd_register_1_o,
   output logic [4:0]            rd_register_2_o,
   input  logic [WIDTH_DATA-1:0] rd_data_1_i,
   input  logic [WIDTH_DATA-1:0] rd_data_2_i,
   input  logic                  wb_reg_write_i,
   input  logic [4:0]            wb_register_i,
   input  logic [WIDTH_DATA-1:0] wb_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [WIDTH_DATA-1:0] out_pc_o,
   output logic [WIDTH_DATA-1:0] out_rs1_data_o,
   output logic [WIDTH_DATA-1:0] out_rs2_data_o,
   output logic [WIDTH_DATA-1:0] out_imm_o,
   output logic [4:0]            out_rd_o,
   output logic [4:0]            out_rs1_o,
   output logic [4:0]            out_rs2_o,
   output logic [2:0]            out_funct3_o,
   output logic                  out_funct7b5_o,
   output logic [6:0]            out_opcode_o
);

   state_e                state_reg;
   logic                  out_valid_reg;
   logic [WIDTH_DATA-1:0] pc_reg;
   logic [WIDTH_DATA-1:0] rs1_data_reg;
   logic [WIDTH_DATA-1:0] rs2_data_reg;
   logic [WIDTH_DATA-1:0] imm_reg;
   logic [4:0]            rd_reg;
   logic [4:0]            rs1_reg;
   logic [4:0]            rs2_reg;
   logic [2:0]            funct3_reg;
   logic                  funct7b5_reg;
   logic [6:0]            opcode_reg;

   logic [4:0]            rs_addr [2];
   logic [WIDTH_DATA-1:0] rd_data [2];
   logic [WIDTH_DATA-1:0] operand [2];
   logic [WIDTH_DATA-1:0] imm_next;
   logic                  hazard;
   logic                  accept;

   assign rs_addr[0] = instr_i[19:15];
   assign rs_addr[1] = instr_i[24:20];
   assign rd_data[0] = rd_data_1_i;
   assign rd_data[1] = rd_data_2_i;

   assign rd_register_1_o = rs_addr[0];
   assign rd_register_2_o = rs_addr[1];

   // A load still in the output register cannot feed the next instruction yet.
   assign hazard = out_valid_reg && (opcode_reg == OP_LOAD) && (rd_reg != 5'd0) &&
                   ((rd_reg == rs_addr[0]) || (rd_reg == rs_addr[1]));

   // Gated by reset so nothing is taken while the stage is held in reset.
   assign in_ready_o = !reset_i && (!out_valid_reg || out_ready_i) &&
                       (state_reg == RUN) && !hazard;
   assign accept     = in_valid_i && in_ready_o && !flush_i;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_operand
`ifdef DECODE_WB_BYPASS_EN
         assign operand[gi] = (rs_addr[gi] == 5'd0) ? '0 :
                              (wb_reg_write_i && (wb_register_i == rs_addr[gi])) ? wb_data_i :
                              rd_data[gi];
`else
         assign operand[gi] = (rs_addr[gi] == 5'd0) ? '0 : rd_data[gi];
`endif
      end
   endgenerate

`ifndef DECODE_WB_BYPASS_EN
   logic unused_wb;
   assign unused_wb = ^{wb_reg_write_i, wb_register_i, wb_data_i};
`endif

   imm_gen #(
      .WIDTH_DATA(WIDTH_DATA)
   ) u_imm_gen (
      .instr(instr_i),
      .imm  (imm_next)
   );

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_reg     <= RUN;
         out_valid_reg <= 1'b0;
         pc_reg        <= '0;
         rs1_data_reg  <= '0;
         rs2_data_reg  <= '0;
         imm_reg       <= '0;
         rd_reg        <= '0;
         rs1_reg       <= '0;
         rs2_reg       <= '0;
         funct3_reg    <= '0;
         funct7b5_reg  <= 1'b0;
         opcode_reg    <= '0;
      end else if (flush_i) begin
         out_valid_reg <= 1'b0;
         state_reg     <= RUN;
      end else begin
         case (state_reg)
            RUN:     if (hazard && in_valid_i) state_reg <= STALL;
            STALL:   state_reg <= RUN;
            default: state_reg <= RUN;
         endcase
         if (accept) begin
            out_valid_reg <= 1'b1;
            pc_reg        <= WIDTH_DATA'(pc_i);
            rs1_data_reg  <= operand[0];
            rs2_data_reg  <= operand[1];
            imm_reg       <= imm_next;
            rd_reg        <= instr_i[11:7];
            rs1_reg       <= rs_addr[0];
            rs2_reg       <= rs_addr[1];
            funct3_reg    <= instr_i[14:12];
            funct7b5_reg  <= instr_i[30];
            opcode_reg    <= instr_i[6:0];
         end else if (out_ready_i) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign out_valid_o    = out_valid_reg;
   assign out_pc_o       = pc_reg;
   assign out_rs1_data_o = rs1_data_reg;
   assign out_rs2_data_o = rs2_data_reg;
   assign out_imm_o      = imm_reg;
   assign out_rd_o       = rd_reg;
   assign out_rs1_o      = rs1_reg;
   assign out_rs2_o      = rs2_reg;
   assign out_funct3_o   = funct3_reg;
   assign out_funct7b5_o = funct7b5_reg;
   assign out_opcode_o   = opcode_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; expectations follow the
// DECODE_WB_BYPASS_EN setting of the build.
`timescale 1ns/100ps
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        flush;
   logic [4:0]  rd_reg1, rd_reg2;
   logic [31:0] rd1, rd2;
   logic        wb_we;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic [2:0]  out_funct3;
   logic        out_funct7b5;
   logic [6:0]  out_opcode;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   decode_stage #(.WIDTH_DATA(32)) dut (
      .clock_i        (clk),
      .reset_i        (rst),
      .in_valid_i     (in_valid),
      .in_ready_o     (in_ready),
      .instr_i        (instr),
      .pc_i           (pc),
      .flush_i        (flush),
      .rd_register_1_o(rd_reg1),
      .rd_register_2_o(rd_reg2),
      .rd_data_1_i    (rd1),
      .rd_data_2_i    (rd2),
      .wb_reg_write_i (wb_we),
      .wb_register_i  (wb_reg),
      .wb_data_i      (wb_data),
      .out_valid_o    (out_valid),
      .out_ready_i    (out_ready),
      .out_pc_o       (out_pc),
      .out_rs1_data_o (out_rs1_data),
      .out_rs2_data_o (out_rs2_data),
      .out_imm_o      (out_imm),
      .out_rd_o       (out_rd),
      .out_rs1_o      (out_rs1),
      .out_rs2_o      (out_rs2),
      .out_funct3_o   (out_funct3),
      .out_funct7b5_o (out_funct7b5),
      .out_opcode_o   (out_opcode)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic offer(input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] d1, input logic [31:0] d2);
      in_valid = 1'b1;
      instr    = ins;
      pc       = p;
      rd1      = d1;
      rd2      = d2;
   endtask

   localparam logic [31:0] ADDI_X1 = 32'h00500093;  // addi x1,x0,5
   localparam logic [31:0] LW_X2   = 32'h0000A103;  // lw   x2,0(x1)
   localparam logic [31:0] ADD_X3  = 32'h001101B3;  // add  x3,x2,x1
   localparam logic [31:0] SW_X2   = 32'h0020A423;  // sw   x2,8(x1)
   localparam logic [31:0] LUI_X6  = 32'h12345337;  // lui  x6,0x12345
   localparam logic [31:0] JAL_M8  = 32'hFF9FF0EF;  // jal  x1,-8
   localparam logic [31:0] SUB_X5  = 32'h402082B3;  // sub  x5,x1,x2
   localparam logic [31:0] BEQ_M4  = 32'hFE000EE3;  // beq  x0,x0,-4
   localparam logic [31:0] BAD_OP  = 32'h0000007F;
   localparam logic [31:0] ADDI_X7 = 32'h00008393;  // addi x7,x1,0

   logic [31:0] held_pc;

   initial begin
      rst = 1'b1; in_valid = 1'b0; instr = '0; pc = '0; flush = 1'b0;
      rd1 = '0; rd2 = '0; wb_we = 1'b0; wb_reg = '0; wb_data = '0; out_ready = 1'b1;

      #10;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_in_ready",  {31'b0, in_ready},  32'd0);
      chk("rst_imm",       out_imm,            32'd0);
      chk("rst_rd",        {27'b0, out_rd},    32'd0);
      #4;
      rst = 1'b0;
      offer(ADDI_X1, 32'h100, 32'h12345678, 32'h0);
      #0.5;
      chk("addi_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      chk("addi_valid", {31'b0, out_valid}, 32'd1);
      chk("addi_rd",    {27'b0, out_rd},    32'd1);
      chk("addi_imm",   out_imm,            32'd5);
      chk("addi_rs1_x0", out_rs1_data,      32'd0);
      chk("addi_pc",    out_pc,             32'h100);

      offer(SW_X2, 32'h104, 32'h11111111, 32'h22222222);
      #1 chk("sw_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      chk("sw_imm",    out_imm,                32'd8);
      chk("sw_rs1d",   out_rs1_data,           32'h11111111);
      chk("sw_rs2d",   out_rs2_data,           32'h22222222);
      chk("sw_funct3", {29'b0, out_funct3},    32'd2);
      chk("sw_opcode", {25'b0, out_opcode},    32'h23);

      offer(LUI_X6, 32'h108, 32'h11111111, 32'h22222222);
      tick();
      chk("lui_imm", out_imm,             32'h12345000);
      chk("lui_rd",  {27'b0, out_rd},     32'd6);

      offer(JAL_M8, 32'h10C, 32'h11111111, 32'h22222222);
      tick();
      chk("jal_imm", out_imm, 32'hFFFFFFF8);

      offer(SUB_X5, 32'h110, 32'h11111111, 32'h22222222);
      tick();
      chk("sub_f7b5", {31'b0, out_funct7b5}, 32'd1);
      chk("sub_rs2d", out_rs2_data,          32'h22222222);
      chk("sub_imm",  out_imm,               32'd0);

      offer(BEQ_M4, 32'h114, 32'hFFFFFFFF, 32'hFFFFFFFF);
      tick();
      chk("beq_imm",    out_imm,      32'hFFFFFFFC);
      chk("beq_rs1_x0", out_rs1_data, 32'd0);

      offer(BAD_OP, 32'h118, 32'h11111111, 32'h22222222);
      tick();
      chk("badop_imm", out_imm, 32'd0);

      // Writeback bypass against register-file data.
      offer(ADDI_X7, 32'h11C, 32'hAAAAAAAA, 32'h0);
      wb_we = 1'b1; wb_reg = 5'd1; wb_data = 32'h55555555;
      tick();
      wb_we = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
      chk("byp_rs1d", out_rs1_data, 32'h55555555);
`else
      chk("byp_rs1d", out_rs1_data, 32'hAAAAAAAA);
`endif
      chk("byp_rd", {27'b0, out_rd}, 32'd7);

      // Backpressure: output must hold while out_ready is low.
      held_pc   = out_pc;
      out_ready = 1'b0;
      offer(ADDI_X1, 32'h120, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         #1 chk($sformatf("hold%0d_in_ready", i), {31'b0, in_ready}, 32'd0);
         tick();
         chk($sformatf("hold%0d_valid", i), {31'b0, out_valid}, 32'd1);
         chk($sformatf("hold%0d_rd", i),    {27'b0, out_rd},    32'd7);
         chk($sformatf("hold%0d_pc", i),    out_pc,             held_pc);
      end
      out_ready = 1'b1;
      #1 chk("release_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      chk("replace_valid", {31'b0, out_valid}, 32'd1);
      chk("replace_pc",    out_pc,             32'h120);

      // Load-use: hazard cycle, stall cycle, then the add is taken.
      offer(LW_X2, 32'h124, 32'h0, 32'h0);
      #1 chk("lw_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      chk("lw_opcode", {25'b0, out_opcode}, 32'h03);
      offer(ADD_X3, 32'h128, 32'h0, 32'h0);
      #1 chk("lu_hazard_rdy", {31'b0, in_ready}, 32'd0);
      tick();
      chk("lu_bubble", {31'b0, out_valid}, 32'd0);
      #1 chk("lu_stall_rdy", {31'b0, in_ready}, 32'd0);
      tick();
      chk("lu_run_rdy", {31'b0, in_ready}, 32'd1);
      tick();
      chk("lu_add_valid", {31'b0, out_valid}, 32'd1);
      chk("lu_add_rd",    {27'b0, out_rd},    32'd3);
      chk("lu_add_pc",    out_pc,             32'h128);

      // Flush during a stall.
      offer(LW_X2, 32'h12C, 32'h0, 32'h0);
      tick();
      offer(ADD_X3, 32'h130, 32'h0, 32'h0);
      tick();
      chk("fl_bubble", {31'b0, out_valid}, 32'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_valid", {31'b0, out_valid}, 32'd0);
      in_valid = 1'b0;
      #1 chk("fl_run_rdy", {31'b0, in_ready}, 32'd1);
      tick();
      chk("fl_not_issued", {31'b0, out_valid}, 32'd0);

      // Flush wins over an acceptable offer.
      offer(ADDI_X1, 32'h134, 32'h0, 32'h0);
      tick();
      chk("fa_valid", {31'b0, out_valid}, 32'd1);
      offer(SW_X2, 32'h138, 32'h0, 32'h0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fa_blocked", {31'b0, out_valid}, 32'd0);

      // Asynchronous reset in the middle of a stall.
      offer(LW_X2, 32'h13C, 32'h0, 32'h0);
      tick();
      offer(ADD_X3, 32'h140, 32'h0, 32'h0);
      tick();
      rst = 1'b1;
      #1;
      chk("mr_valid",    {31'b0, out_valid},   32'd0);
      chk("mr_in_ready", {31'b0, in_ready},    32'd0);
      chk("mr_opcode",   {25'b0, out_opcode},  32'd0);
      chk("mr_pc",       out_pc,               32'd0);
      #2;
      rst = 1'b0;
      offer(ADDI_X1, 32'h200, 32'h0, 32'h0);
      #1 chk("mr_first_rdy", {31'b0, in_ready}, 32'd1);
      tick();
      chk("mr_first_valid", {31'b0, out_valid}, 32'd1);
      chk("mr_first_pc",    out_pc,             32'h200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
